// File: rtl/tow_game_ctrl.sv
// tow_game_ctrl
//
// Game sequencer for the tug-of-war datapath. It arms and disarms the
// push-button latch block through `clear`, moves a one-hot rope position on
// each latched press, and declares a winner when the rope reaches either end.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   pbl, pbr   raw buttons, used only to detect that both are released
//   push       latch block reports a latched press
//   tie        latch block reports both sides latched together
//   right      latch block reports the right side won the press
//   start      new-game request, honoured only once a winner is declared
//   clear      holds the latch block cleared while high
//   leds       one-hot rope position (bit index = position)
//   pos        rope position, 0..N_LEDS-1
//   win_left   left player won (pos == 0)
//   win_right  right player won (pos == N_LEDS-1)
//   armed      high while waiting for a press
//
// Every output is either a register or a decode of the pos register, so no
// input reaches an output combinationally.

module tow_game_ctrl #(
  parameter int N_LEDS     = 9,
  parameter int ARM_CYCLES = 16,
  parameter int POS_W      = $clog2(N_LEDS),
  parameter int CNT_W      = $clog2(ARM_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pbl,
  input  logic              pbr,
  input  logic              push,
  input  logic              tie,
  input  logic              right,
  input  logic              start,
  output logic              clear,
  output logic [N_LEDS-1:0] leds,
  output logic [POS_W-1:0]  pos,
  output logic              win_left,
  output logic              win_right,
  output logic              armed
);

  localparam logic [POS_W-1:0] CENTRE   = POS_W'((N_LEDS - 1) / 2);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ARMED,
    S_WIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] arm_cnt;
  logic [POS_W-1:0] step_pos;

  // Candidate rope position if the current push is taken. A tie leaves the
  // rope where it is; otherwise it moves one step toward the winner of the
  // press. The ends are never passed: the game stops there, but the step is
  // still saturated so an unexpected sequence cannot wrap the position.
  always_comb begin
    step_pos = pos;
    if (tie) begin
      step_pos = pos;
    end else if (right) begin
      if (pos != LAST_POS) begin
        step_pos = pos + POS_W'(1);
      end
    end else begin
      if (pos != '0) begin
        step_pos = pos - POS_W'(1);
      end
    end
  end

  // Main sequencer. CLEAR keeps the latches cleared until both buttons have
  // been released for ARM_CYCLES consecutive edges (any press restarts the
  // count, so a held button blocks arming). ARMED waits for a press and
  // applies it, then returns to CLEAR or declares a winner at an end LED.
  // WIN freezes everything until start recentres the rope. The clear/armed
  // flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      arm_cnt   <= '0;
      pos       <= CENTRE;
      clear     <= 1'b1;
      armed     <= 1'b0;
      win_left  <= 1'b0;
      win_right <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clear <= 1'b1;
          armed <= 1'b0;
          if (pbl || pbr) begin
            arm_cnt <= '0;
          end else if (arm_cnt == CNT_LAST) begin
            arm_cnt <= '0;
            state   <= S_ARMED;
            clear   <= 1'b0;
            armed   <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + CNT_W'(1);
          end
        end

        S_ARMED: begin
          if (push) begin
            pos     <= step_pos;
            clear   <= 1'b1;
            armed   <= 1'b0;
            arm_cnt <= '0;
            if ((step_pos == '0) || (step_pos == LAST_POS)) begin
              state     <= S_WIN;
              win_left  <= (step_pos == '0);
              win_right <= (step_pos == LAST_POS);
            end else begin
              state <= S_CLEAR;
            end
          end
        end

        S_WIN: begin
          clear <= 1'b1;
          armed <= 1'b0;
          if (start) begin
            pos       <= CENTRE;
            win_left  <= 1'b0;
            win_right <= 1'b0;
            arm_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end

        default: begin
          state   <= S_CLEAR;
          arm_cnt <= '0;
          clear   <= 1'b1;
          armed   <= 1'b0;
        end
      endcase
    end
  end

  // The LED bar is a pure decode of the position register.
  assign leds = N_LEDS'(1) << pos;

endmodule

// File: tb/tb_tow_game_ctrl.sv
// tb_tow_game_ctrl
//
// Scoreboard bench for tow_game_ctrl with the default 9 LEDs and a 16-cycle
// arm delay. The stimulus process drives one clock edge at a time and pushes
// the hand-worked output it expects after that edge; a separate monitor pops
// each expectation on the following falling edge and compares it.

module tb_tow_game_ctrl;

  logic       clk;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic       push;
  logic       tie;
  logic       right;
  logic       start;
  logic       clear;
  logic [8:0] leds;
  logic [3:0] pos;
  logic       win_left;
  logic       win_right;
  logic       armed;

  typedef struct packed {
    logic       clear;
    logic       armed;
    logic [3:0] pos;
    logic [8:0] leds;
    logic       win_left;
    logic       win_right;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  tow_game_ctrl #(
    .N_LEDS    (9),
    .ARM_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pbl      (pbl),
    .pbr      (pbr),
    .push     (push),
    .tie      (tie),
    .right    (right),
    .start    (start),
    .clear    (clear),
    .leds     (leds),
    .pos      (pos),
    .win_left (win_left),
    .win_right(win_right),
    .armed    (armed)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs across exactly one rising edge, then settle.
  task automatic applyStimulus(input logic r, input logic b_l, input logic b_r,
                               input logic p, input logic t, input logic rt,
                               input logic st);
    rst   = r;
    pbl   = b_l;
    pbr   = b_r;
    push  = p;
    tie   = t;
    right = rt;
    start = st;
    @(posedge clk);
    #1;
  endtask

  // Queue the outputs expected after the edge just applied.
  task automatic expectOut(input string tag, input logic c, input logic a,
                           input logic [3:0] p, input logic wl, input logic wr);
    exp_t e;
    e.clear     = c;
    e.armed     = a;
    e.pos       = p;
    e.leds      = 9'd1 << p;
    e.win_left  = wl;
    e.win_right = wr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    exp_t got;
    got.clear     = clear;
    got.armed     = armed;
    got.pos       = pos;
    got.leds      = leds;
    got.win_left  = win_left;
    got.win_right = win_right;
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got clear=%b armed=%b pos=%0d leds=%b wl=%b wr=%b, want clear=%b armed=%b pos=%0d leds=%b wl=%b wr=%b",
               tag, got.clear, got.armed, got.pos, got.leds, got.win_left, got.win_right,
               e.clear, e.armed, e.pos, e.leds, e.win_left, e.win_right);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, away from the
  // rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(tag_q.pop_front(), exp_q.pop_front());
    end
  end

  // Starting from CLEAR with the count at 0 and buttons released: 15 edges
  // stay disarmed, the 16th arms.
  task automatic armSeq(input string tag, input logic [3:0] p);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectOut({tag, "_wait"}, 1'b1, 1'b0, p, 1'b0, 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectOut({tag, "_armed"}, 1'b0, 1'b1, p, 1'b0, 1'b0);
  endtask

  // A single non-winning press from ARMED, then re-arm.
  task automatic moveAndArm(input string tag, input logic rt, input logic [3:0] p);
    applyStimulus(0, 0, 0, 1, 0, rt, 0);
    expectOut({tag, "_move"}, 1'b1, 1'b0, p, 1'b0, 1'b0);
    armSeq(tag, p);
  endtask

  initial begin
    rst = 1'b1; pbl = 1'b0; pbr = 1'b0;
    push = 1'b0; tie = 1'b0; right = 1'b0; start = 1'b0;

    // Reset for two edges, then release and arm at the centre.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    expectOut("reset0", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    expectOut("reset1", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    armSeq("boot", 4'd4);

    // Tie (right also set): rope stays, latches cleared. A held left button
    // then blocks arming for 40 cycles.
    applyStimulus(0, 1, 1, 1, 1, 1, 0);
    expectOut("tie", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      expectOut("held_pbl", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    end
    armSeq("after_tie", 4'd4);

    // Right move while pbr is down, pbr held 3 more cycles, then release.
    applyStimulus(0, 0, 1, 1, 0, 1, 0);
    expectOut("right_move", 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      expectOut("held_pbr", 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    end
    armSeq("after_right", 4'd5);

    // Right to 6; during re-arm a pbl pulse at count 10 restarts the count.
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    expectOut("right_6", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectOut("count_to_10", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    expectOut("pbl_pulse", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
    armSeq("restart", 4'd6);

    // Reset mid-game while armed at 6 (start asserted too: reset wins).
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    expectOut("mid_reset", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    armSeq("post_reset", 4'd4);

    // Four right presses from centre: the fourth wins.
    moveAndArm("r5", 1'b1, 4'd5);
    moveAndArm("r6", 1'b1, 4'd6);
    moveAndArm("r7", 1'b1, 4'd7);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    expectOut("right_win", 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);

    // Presses and buttons are ignored in WIN.
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    expectOut("win_hold_push", 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectOut("win_hold_idle", 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    expectOut("win_hold_tie", 1'b1, 1'b0, 4'd8, 1'b0, 1'b1);

    // start recentres and begins the re-arm sequence.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    expectOut("start", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    armSeq("new_game", 4'd4);

    // start is ignored while armed.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    expectOut("start_armed", 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);

    // Four left presses from centre: the fourth wins for the left.
    moveAndArm("l3", 1'b0, 4'd3);
    moveAndArm("l2", 1'b0, 4'd2);
    moveAndArm("l1", 1'b0, 4'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    expectOut("left_win", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1, 1, 0, 1, 0);
    expectOut("left_hold", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

    // start together with rst gives the reset values.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    expectOut("rst_start", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectOut("after_rst", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want bench to finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
